// File: rtl/math_cabs_arb.sv
// Round-robin scheduler sharing one math_cabs_16 magnitude pipeline between N requesters.
// Issues at most one tagged sample per cycle and returns each result with its requester ID in issue order.
module math_cabs_arb #(
  parameter int N   = 4,
  parameter int LAT = 9,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*16-1:0] req_a,
  input  logic [N*16-1:0] req_b,
  output logic            cabs_ena,
  output logic            cabs_rst,
  output logic [15:0]     cabs_dina,
  output logic [15:0]     cabs_dinb,
  input  logic [16:0]     cabs_dout,
  output logic            out_valid,
  output logic [IDW-1:0]  out_id,
  output logic [16:0]     out_data,
  output logic            busy
);

  logic [15:0] w_slice_a [N];
  logic [15:0] w_slice_b [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign w_slice_a[g] = req_a[16*g +: 16];
    assign w_slice_b[g] = req_b[16*g +: 16];
  end

  logic           r_rst_meta;
  logic           r_cabs_rst;
  logic [IDW-1:0] r_ptr;
  logic [15:0]    r_dina;
  logic [15:0]    r_dinb;
  logic [LAT:0]   r_tag_v;            // bit 0 is the issue tag, bit k tracks pipeline stage k
  logic [IDW-1:0] r_tag_id [LAT+1];
  logic           r_out_valid;
  logic [IDW-1:0] r_out_id;
  logic [16:0]    r_out_data;

  logic           w_can_grant;
  logic           w_found;
  logic           w_hs;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_win_id;
  logic [N-1:0]   w_grant;

  assign w_can_grant = en & ~r_cabs_rst;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = w_idx;
      end
    end
  end

  assign w_hs = w_can_grant & w_found;

  always_comb begin
    w_grant = '0;
    if (w_hs) w_grant[w_win_id] = 1'b1;
  end

  // cabs_rst follows rst low immediately and releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_meta <= 1'b1;
      r_cabs_rst <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_cabs_rst <= r_rst_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= IDW'(N - 1);
      r_dina      <= '0;
      r_dinb      <= '0;
      // NOTE: the tag pipe is reset; a stale valid bit would surface as a phantom result.
      r_tag_v     <= '0;
      for (int s = 0; s <= LAT; s++) r_tag_id[s] <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_hs) begin
        r_ptr  <= w_win_id;
        r_dina <= w_slice_a[w_win_id];
        r_dinb <= w_slice_b[w_win_id];
      end
      // Tags advance only with the pipeline enable so they stay aligned with cabs_dout.
      if (en) begin
        r_tag_v     <= {r_tag_v[LAT-1:0], w_hs};
        r_tag_id[0] <= w_win_id;
        for (int s = 1; s <= LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
        r_out_valid <= r_tag_v[LAT];
        r_out_id    <= r_tag_id[LAT];
        r_out_data  <= cabs_dout;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_grant;
  assign cabs_ena  = en;
  assign cabs_rst  = r_cabs_rst;
  assign cabs_dina = r_dina;
  assign cabs_dinb = r_dinb;
  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_data  = r_out_data;
  assign busy      = |r_tag_v;

endmodule

// File: tb/tb_math_cabs_arb.sv
// Self-checking bench for math_cabs_arb: directed scenarios plus randomized traffic against a
// queue-based reference model; math_cabs_16 is modelled as a LAT-deep enabled delay line.
module tb_math_cabs_arb;
  localparam int N   = 4;
  localparam int LAT = 9;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic            cabs_ena;
  logic            cabs_rst;
  logic [15:0]     cabs_dina;
  logic [15:0]     cabs_dinb;
  logic [16:0]     cabs_dout;
  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic [16:0]     out_data;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  math_cabs_arb #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .cabs_ena(cabs_ena), .cabs_rst(cabs_rst), .cabs_dina(cabs_dina), .cabs_dinb(cabs_dinb),
    .cabs_dout(cabs_dout),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data), .busy(busy)
  );

  function automatic int mag(logic [15:0] a, logic [15:0] b);
    int  ia, ib;
    real ra, rb;
    ia = int'($signed(a));
    ib = int'($signed(b));
    ra = $itor(ia);
    rb = $itor(ib);
    return $rtoi($sqrt(ra * ra + rb * rb) + 0.5);
  endfunction

  // External magnitude pipeline: result of the sampled inputs appears LAT enabled clocks later.
  logic [16:0] cabs_pipe [LAT];
  assign cabs_dout = cabs_pipe[LAT-1];
  always @(posedge clk) begin
    if (cabs_rst) begin
      for (int i = 0; i < LAT; i++) cabs_pipe[i] <= '0;
    end else if (cabs_ena) begin
      cabs_pipe[0] <= 17'(mag(cabs_dina, cabs_dinb));
      for (int i = 1; i < LAT; i++) cabs_pipe[i] <= cabs_pipe[i-1];
    end
  end

  function automatic int rr_pick(int ptr, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Reference model: a queue of results, each due a fixed number of enabled edges after issue.
  typedef struct { int due; int id; int mag; } res_t;
  res_t q[$];
  int   m_ptr = N - 1;
  int   m_rst_cnt = 2;
  int   m_ecnt = 0;
  int   m_win;
  logic m_ov = 1'b0;
  int   m_oid = 0;
  int   m_odata = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ptr     = N - 1;
      m_rst_cnt = 2;
      m_ov      = 1'b0;
    end else begin
      m_win = (en && m_rst_cnt == 0) ? rr_pick(m_ptr, req_valid) : -1;
      if (m_rst_cnt > 0) m_rst_cnt--;
      m_ov = 1'b0;
      if (en) begin
        m_ecnt++;
        if (q.size() > 0 && q[0].due == m_ecnt) begin
          m_ov    = 1'b1;
          m_oid   = q[0].id;
          m_odata = q[0].mag;
          void'(q.pop_front());
        end
        if (m_win >= 0) begin
          q.push_back('{m_ecnt + LAT + 1, m_win, mag(req_a[16*m_win +: 16], req_b[16*m_win +: 16])});
          m_ptr = m_win;
        end
      end
    end
  end

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] g;
    int w;
    g = '0;
    if (rst === 1'b1 && en === 1'b1 && m_rst_cnt == 0) begin
      w = rr_pick(m_ptr, req_valid);
      if (w >= 0) g[w] = 1'b1;
    end
    return g;
  endfunction

  task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({req_ready, out_valid, busy, cabs_rst} !== {{N{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_ctrl: got ready=%b ov=%b busy=%b cabs_rst=%b want 0000 0 0 1",
                 req_ready, out_valid, busy, cabs_rst);
      end
      n_cmp++;
      if ({out_id, out_data, cabs_dina, cabs_dinb} !== '0) begin
        n_bad++;
        $display("FAIL reset_regs: got id=%0d data=%0d dina=%h dinb=%h want all 0",
                 out_id, out_data, cabs_dina, cabs_dinb);
      end
    end
    @(negedge clk); rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (cabs_rst !== (i < 2) || req_ready !== ((i < 2) ? 4'b0000 : 4'b0001)) begin
        n_bad++;
        $display("FAIL reset_release[%0d]: got cabs_rst=%b ready=%b want %b %b", i, cabs_rst, req_ready,
                 (i < 2), (i < 2) ? 4'b0000 : 4'b0001);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int   first = -1;
    int   hits = 0;
    logic busy_prev = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100; set_slot(2, 16'd3, 16'd4); #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); req_valid = '0; #1;
      if (out_valid === 1'b1) begin
        hits++;
        if (first < 0) begin
          first = k;
          n_cmp++;
          if (out_id !== 2'd2 || out_data !== 17'd5 || busy_prev !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_result: got id=%0d data=%0d busy %b->%b want id=2 data=5 busy 1->0",
                     out_id, out_data, busy_prev, busy);
          end
        end
      end
      busy_prev = busy;
    end
    n_cmp++;
    if (first != LAT + 2 || hits != 1) begin
      n_bad++; $display("FAIL single_latency: got cycle=%0d count=%0d want cycle=%0d count=1", first, hits, LAT + 2);
    end
  endtask

  task automatic test_all_valid();
    int exp_mag [8];
    int n = 0;
    int last_k = 0;
    logic [15:0] a, b;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1; req_valid = '1;
      for (int j = 0; j < N; j++) set_slot(j, 16'($urandom), 16'($urandom));
      a = req_a[16*(i%N) +: 16];
      b = req_b[16*(i%N) +: 16];
      exp_mag[i] = mag(a, b);
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << (i % N))) begin
        n_bad++; $display("FAIL all_valid_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << (i % N)));
      end
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); req_valid = '0; #1;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (n >= 8 || out_id !== IDW'(n % N) || out_data !== 17'(exp_mag[n % 8]) || (n > 0 && k != last_k + 1)) begin
          n_bad++;
          $display("FAIL all_valid_out[%0d]: got id=%0d data=%0d k=%0d want id=%0d data=%0d k=%0d",
                   n, out_id, out_data, k, n % N, exp_mag[n % 8], (n > 0) ? last_k + 1 : k);
        end
        last_k = k;
        n++;
      end
    end
    n_cmp++;
    if (n != 8) begin n_bad++; $display("FAIL all_valid_count: got %0d want 8", n); end
  endtask

  task automatic test_alternate();
    int exp_mag [8];
    int n = 0;
    logic [N-1:0] exp_g;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 4'b1010;
      for (int j = 0; j < N; j++) set_slot(j, 16'($urandom), 16'($urandom));
      exp_mag[i] = mag(req_a[16*(1+2*(i%2)) +: 16], req_b[16*(1+2*(i%2)) +: 16]);
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      #1;
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++; $display("FAIL alternate_grant[%0d]: got %b want %b", i, req_ready, exp_g);
      end
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); req_valid = '0; #1;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (n >= 8 || out_id !== IDW'(1 + 2 * (n % 2)) || out_data !== 17'(exp_mag[n % 8])) begin
          n_bad++;
          $display("FAIL alternate_out[%0d]: got id=%0d data=%0d want id=%0d data=%0d",
                   n, out_id, out_data, 1 + 2 * (n % 2), exp_mag[n % 8]);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 8) begin n_bad++; $display("FAIL alternate_count: got %0d want 8", n); end
  endtask

  task automatic test_freeze();
    int exp_mag [6];
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = 1'b1; req_valid = '1;
      for (int j = 0; j < N; j++) set_slot(j, 16'($urandom), 16'($urandom));
      exp_mag[i] = mag(req_a[16*(i%N) +: 16], req_b[16*(i%N) +: 16]);
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << (i % N))) begin
        n_bad++; $display("FAIL freeze_grant[%0d]: got %b want %b", i, req_ready, 4'(1 << (i % N)));
      end
    end
    for (int c = 6; c < 11; c++) begin
      @(negedge clk); en = 1'b0; #1;
      n_cmp++;
      if (req_ready !== '0 || out_valid !== 1'b0 || cabs_ena !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL freeze_hold[%0d]: got ready=%b ov=%b ena=%b busy=%b want 0000 0 0 1",
                 c, req_ready, out_valid, cabs_ena, busy);
      end
    end
    for (int c = 11; c < 50; c++) begin
      @(negedge clk); en = 1'b1; req_valid = '0; #1;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (n >= 6 || c != LAT + 7 + n || out_id !== IDW'(n % N) || out_data !== 17'(exp_mag[n % 6])) begin
          n_bad++;
          $display("FAIL freeze_out[%0d]: got cycle=%0d id=%0d data=%0d want cycle=%0d id=%0d data=%0d",
                   n, c, out_id, out_data, LAT + 7 + n, n % N, exp_mag[n % 6]);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 6) begin n_bad++; $display("FAIL freeze_count: got %0d want 6", n); end
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    logic [N-1:0] exp_g;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b1; req_valid = '1;
      for (int j = 0; j < N; j++) set_slot(j, 16'($urandom), 16'($urandom));
      #1;
      exp_g = model_ready();
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++; $display("FAIL reset_mid_grant[%0d]: got %b want %b", i, req_ready, exp_g);
      end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if ({out_valid, busy, req_ready, cabs_dina, cabs_dinb, out_data, out_id} !== '0 || cabs_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got ov=%b busy=%b ready=%b dina=%h data=%0d cabs_rst=%b want zeros, cabs_rst=1",
               out_valid, busy, req_ready, cabs_dina, out_data, cabs_rst);
    end
    @(negedge clk);
    @(negedge clk); rst = 1'b1; req_valid = '0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (cabs_rst !== (i < 2)) begin
        n_bad++; $display("FAIL reset_mid_release[%0d]: got cabs_rst=%b want %b", i, cabs_rst, (i < 2));
      end
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    n_cmp++;
    if (hits != 0) begin n_bad++; $display("FAIL reset_mid_stale: got %0d active cycles want 0", hits); end
  endtask

  task automatic test_extremes();
    int   n = 0;
    logic busy_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      set_slot(1, (i == 0) ? 16'h8000 : 16'h0000, (i == 0) ? 16'h8000 : 16'h0000);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010) begin
        n_bad++; $display("FAIL extreme_grant[%0d]: got %b want 0010", i, req_ready);
      end
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); req_valid = '0; #1;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (n == 0 && (out_id !== 2'd1 || out_data < 17'd46340 || out_data > 17'd46342)) begin
          n_bad++; $display("FAIL extreme_max: got id=%0d data=%0d want id=1 data=46341+/-1", out_id, out_data);
        end
        if (n == 1 && (out_id !== 2'd1 || out_data !== 17'd0 || busy_prev !== 1'b1 || busy !== 1'b0)) begin
          n_bad++;
          $display("FAIL extreme_zero: got id=%0d data=%0d busy %b->%b want id=1 data=0 busy 1->0",
                   out_id, out_data, busy_prev, busy);
        end
        n++;
      end
      busy_prev = busy;
    end
    n_cmp++;
    if (n != 2) begin n_bad++; $display("FAIL extreme_count: got %0d want 2", n); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    logic [15:0]  a, b;
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      if (i < 300) begin
        en        = ($urandom_range(0, 7) != 0);
        req_valid = N'($urandom);
        for (int j = 0; j < N; j++) begin
          a = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
          b = ($urandom_range(0, 9) == 0) ? 16'h7fff : 16'($urandom);
          set_slot(j, a, b);
        end
      end else begin
        en = 1'b1; req_valid = '0;
      end
      #1;
      exp_g = model_ready();
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++; $display("FAIL random_grant[%0d]: got %b want %b", i, req_ready, exp_g);
      end
      n_cmp++;
      if (out_valid !== m_ov) begin
        n_bad++; $display("FAIL random_valid[%0d]: got %b want %b", i, out_valid, m_ov);
      end
      if (m_ov) begin
        n_cmp++;
        if (out_id !== IDW'(m_oid) || out_data !== 17'(m_odata)) begin
          n_bad++;
          $display("FAIL random_result[%0d]: got id=%0d data=%0d want id=%0d data=%0d",
                   i, out_id, out_data, m_oid, m_odata);
        end
      end
      n_cmp++;
      if (busy !== (q.size() != 0)) begin
        n_bad++; $display("FAIL random_busy[%0d]: got %b want %b", i, busy, (q.size() != 0));
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_alternate();
    test_freeze();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
